mcm_pipe: RTL and testbench



---
 rtl/mcm_pipe.sv | 129 ++++++++++++
 tb/tb_mcm_pipe.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcm_pipe.sv
// Two-stage multiple-constant-multiplier pipeline: per lane, X times four mode-selected
// coefficients plus their sum, built from shifts and adds, with ready/valid flow control.
module mcm_pipe #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic [LANES*IN_W-1:0]  X,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] Y1,
    output logic [LANES*OUT_W-1:0] Y2,
    output logic [LANES*OUT_W-1:0] Y3,
    output logic [LANES*OUT_W-1:0] Y4,
    output logic [LANES*OUT_W-1:0] SUM,
    output logic [1:0]             out_mode
);

    logic                   s1_valid_q;
    logic [LANES*IN_W-1:0]  s1_x_q;
    logic [1:0]             s1_mode_q;
    logic                   s2_valid_q;
    logic [LANES*OUT_W-1:0] y1_q, y2_q, y3_q, y4_q, sum_q;
    logic [1:0]             mode_q;
    logic [LANES*OUT_W-1:0] y1_d, y2_d, y3_d, y4_d, sum_d;
    logic                   s2_adv;
    logic                   s1_load;

    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign s1_load  = in_valid & (~s1_valid_q | s2_adv);
    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_mode_q  <= '0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_x_q     <= X;
            s1_mode_q  <= mode;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [OUT_W-1:0] xe;
        logic [OUT_W-1:0] c1, c2, c3, c4;

        assign xe = {{(OUT_W - IN_W){1'b0}}, s1_x_q[k*IN_W +: IN_W]};

        // Constant products decomposed into power-of-two terms
        always_comb begin
            c1 = '0;
            c2 = '0;
            c3 = '0;
            c4 = '0;
            unique case (s1_mode_q)
                2'd0: begin
                    c1 = -(xe + (xe << 1));
                    c2 = -(xe << 1);
                    c3 = (xe << 3) + (xe << 2);
                    c4 = xe << 2;
                end
                2'd1: begin
                    c1 = -(xe << 1);
                    c2 = (xe << 6) - (xe << 2) - (xe << 1);
                    c3 = (xe << 3) + (xe << 1);
                    c4 = -(xe << 1);
                end
                2'd2: begin
                    c1 = -(xe << 2);
                    c2 = (xe << 5) + (xe << 2);
                    c3 = (xe << 5) + (xe << 2);
                    c4 = -(xe << 2);
                end
                2'd3: begin
                    c1 = xe << 4;
                    c2 = xe << 5;
                    c3 = xe << 4;
                    c4 = '0;
                end
            endcase
        end

        assign y1_d[k*OUT_W +: OUT_W]  = c1;
        assign y2_d[k*OUT_W +: OUT_W]  = c2;
        assign y3_d[k*OUT_W +: OUT_W]  = c3;
        assign y4_d[k*OUT_W +: OUT_W]  = c4;
        assign sum_d[k*OUT_W +: OUT_W] = c1 + c2 + c3 + c4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            y1_q       <= '0;
            y2_q       <= '0;
            y3_q       <= '0;
            y4_q       <= '0;
            sum_q      <= '0;
            mode_q     <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= 1'b1;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            y3_q       <= y3_d;
            y4_q       <= y4_d;
            sum_q      <= sum_d;
            mode_q     <= s1_mode_q;
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign Y1        = y1_q;
    assign Y2        = y2_q;
    assign Y3        = y3_q;
    assign Y4        = y4_q;
    assign SUM       = sum_q;
    assign out_mode  = mode_q;

endmodule

// File: tb/tb_mcm_pipe.sv
// Bench for mcm_pipe: directed scenarios plus a randomized stream checked against an
// arithmetic model of the coefficient table and an in-order queue of accepted beats.
module tb_mcm_pipe;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int LANES = 4;
    localparam int XW    = LANES * IN_W;
    localparam int W     = LANES * OUT_W;
    localparam int BW    = 5 * W + 2;
    localparam int NBEATS = 10000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    mode = '0;
    logic [XW-1:0] X = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  Y1, Y2, Y3, Y4, SUM;
    logic [1:0]    out_mode;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [XW-1:0] x;
        int            m;
    } beat_t;

    mcm_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .X(X), .out_valid(out_valid), .out_ready(out_ready), .Y1(Y1), .Y2(Y2), .Y3(Y3),
        .Y4(Y4), .SUM(SUM), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    // Coefficient table; c == 4 selects the sum of the four coefficients
    function automatic int coef(int m, int c);
        int t [4];
        case (m)
            0:       t = '{-3, -2, 12, 4};
            1:       t = '{-2, 58, 10, -2};
            2:       t = '{-4, 36, 36, -4};
            default: t = '{16, 32, 16, 0};
        endcase
        if (c == 4) return t[0] + t[1] + t[2] + t[3];
        return t[c];
    endfunction

    function automatic logic [W-1:0] ref_y(logic [XW-1:0] x, int m, int c);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++)
            r[k*OUT_W +: OUT_W] = OUT_W'(int'(x[k*IN_W +: IN_W]) * coef(m, c));
        return r;
    endfunction

    function automatic logic [BW-1:0] exp_beat(logic [XW-1:0] x, int m);
        return {ref_y(x, m, 0), ref_y(x, m, 1), ref_y(x, m, 2), ref_y(x, m, 3),
                ref_y(x, m, 4), 2'(m)};
    endfunction

    function automatic logic [W-1:0] rep(int v);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*OUT_W +: OUT_W] = OUT_W'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] lanes4(int a, int b, int c, int d);
        return {OUT_W'(d), OUT_W'(c), OUT_W'(b), OUT_W'(a)};
    endfunction

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*IN_W +: IN_W] = IN_W'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if ({Y1, Y2, Y3, Y4, SUM, out_mode} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {Y1, Y2, Y3, Y4, SUM, out_mode});
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid = 1'b1;
        X = {LANES{8'd255}};
        mode = 2'd0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_early: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got out_valid=%b want 1", out_valid);
        end
        checks++;
        if ({Y1, Y2, Y3, Y4, SUM} !== {rep(-765), rep(-510), rep(3060), rep(1020), rep(2805)})
        begin
            errors++;
            $display("FAIL basic_values: got %h %h %h %h %h want lanes -765 -510 3060 1020 2805",
                     Y1, Y2, Y3, Y4, SUM);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [XW-1:0] xs [4];
        int exp_sum [4] = '{110, 640, 640, 640};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) begin
                xs[i] = rand_x();
                xs[i][IN_W-1:0] = IN_W'(10);
                in_valid = 1'b1;
                X = xs[i];
                mode = 2'(i);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (i < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready beat %0d: got %b want 1", i, in_ready);
                end
            end
            if (i >= 2 && i < 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_mode !== 2'(i - 2)) begin
                    errors++;
                    $display("FAIL b2b_stream beat %0d: got valid=%b mode=%0d want 1 mode=%0d",
                             i - 2, out_valid, out_mode, i - 2);
                end
                checks++;
                if (SUM[OUT_W-1:0] !== OUT_W'(exp_sum[i-2])) begin
                    errors++;
                    $display("FAIL b2b_sum_lane0 beat %0d: got %0d want %0d", i - 2,
                             $signed(SUM[OUT_W-1:0]), exp_sum[i-2]);
                end
                checks++;
                if ({Y1, Y2, Y3, Y4, SUM, out_mode} !== exp_beat(xs[i-2], i - 2)) begin
                    errors++;
                    $display("FAIL b2b_all_lanes beat %0d: got %h want %h", i - 2,
                             {Y1, Y2, Y3, Y4, SUM, out_mode}, exp_beat(xs[i-2], i - 2));
                end
                if (i == 3) begin
                    checks++;
                    if (Y2[OUT_W-1:0] !== 16'd580) begin
                        errors++;
                        $display("FAIL b2b_y2_mode1: got %0d want 580", Y2[OUT_W-1:0]);
                    end
                end
            end
            if (i == 6) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
                end
            end
        end
    endtask

    task automatic test_lanes();
        @(negedge clk);
        in_valid = 1'b1;
        X = {8'd255, 8'd128, 8'd1, 8'd0};
        mode = 2'd2;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || Y2 !== lanes4(0, 36, 4608, 9180)) begin
            errors++;
            $display("FAIL lanes_y2: got valid=%b %h want 1 %h", out_valid, Y2,
                     lanes4(0, 36, 4608, 9180));
        end
        checks++;
        if (Y1 !== lanes4(0, -4, -512, -1020)) begin
            errors++;
            $display("FAIL lanes_y1: got %h want %h", Y1, lanes4(0, -4, -512, -1020));
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [XW-1:0] xa, xb, xc;
        xa = rand_x();
        xb = rand_x();
        xc = rand_x();
        @(negedge clk);
        in_valid = 1'b1;
        X = xa;
        mode = 2'd1;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept_a: got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        X = xb;
        mode = 2'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept_b: got in_ready=%b want 1", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            X = xc;
            mode = 2'd3;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall_ready cycle %0d: got %b want 0", i, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || {Y1, Y2, Y3, Y4, SUM, out_mode} !== exp_beat(xa, 1)) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b %h want 1 %h", i, out_valid,
                         {Y1, Y2, Y3, Y4, SUM, out_mode}, exp_beat(xa, 1));
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
            {Y1, Y2, Y3, Y4, SUM, out_mode} !== exp_beat(xa, 1)) begin
            errors++;
            $display("FAIL bp_release_a: got rdy=%b valid=%b %h want 1 1 %h", in_ready,
                     out_valid, {Y1, Y2, Y3, Y4, SUM, out_mode}, exp_beat(xa, 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || {Y1, Y2, Y3, Y4, SUM, out_mode} !== exp_beat(xb, 2)) begin
            errors++;
            $display("FAIL bp_release_b: got valid=%b %h want 1 %h", out_valid,
                     {Y1, Y2, Y3, Y4, SUM, out_mode}, exp_beat(xb, 2));
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || {Y1, Y2, Y3, Y4, SUM, out_mode} !== exp_beat(xc, 3)) begin
            errors++;
            $display("FAIL bp_release_c: got valid=%b %h want 1 %h", out_valid,
                     {Y1, Y2, Y3, Y4, SUM, out_mode}, exp_beat(xc, 3));
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        in_valid = 1'b1;
        X = rand_x();
        mode = 2'd0;
        out_ready = 1'b1;
        @(negedge clk);
        X = rand_x();
        mode = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_inflight_pre: got out_valid=%b want 1", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {Y1, Y2, Y3, Y4, SUM, out_mode} !== '0) begin
            errors++;
            $display("FAIL rst_inflight_clear: got valid=%b %h want 0 0", out_valid,
                     {Y1, Y2, Y3, Y4, SUM, out_mode});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_inflight_stale cycle %0d: got out_valid=%b want 0", i,
                         out_valid);
            end
        end
    endtask

    task automatic test_random();
        beat_t          q [$];
        beat_t          b;
        int             sent = 0;
        int             recv = 0;
        int             cyc = 0;
        logic           held = 1'b0;
        logic [BW-1:0]  held_v = '0;
        logic           exp_rdy;
        while ((sent < NBEATS || q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
            X = rand_x();
            mode = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            // Two beats in flight means both stages are full
            exp_rdy = (q.size() < 2) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_in_ready cycle %0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || {Y1, Y2, Y3, Y4, SUM, out_mode} !== held_v) begin
                    errors++;
                    $display("FAIL rand_hold cycle %0d: got valid=%b %h want 1 %h", cyc,
                             out_valid, {Y1, Y2, Y3, Y4, SUM, out_mode}, held_v);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_beat cycle %0d: got unexpected beat want none",
                             cyc);
                end else begin
                    b = q.pop_front();
                    recv++;
                    if ({Y1, Y2, Y3, Y4, SUM, out_mode} !== exp_beat(b.x, b.m)) begin
                        errors++;
                        $display("FAIL rand_beat %0d: got %h want %h", recv,
                                 {Y1, Y2, Y3, Y4, SUM, out_mode}, exp_beat(b.x, b.m));
                    end
                end
            end
            held = out_valid && !out_ready;
            held_v = {Y1, Y2, Y3, Y4, SUM, out_mode};
            if (in_valid && in_ready) begin
                b.x = X;
                b.m = int'(mode);
                q.push_back(b);
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (recv != NBEATS || q.size() != 0) begin
            errors++;
            $display("FAIL rand_complete: got %0d beats (%0d pending) want %0d", recv, q.size(),
                     NBEATS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_lanes();
        test_backpressure();
        test_reset_inflight();
        test_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule
